ahb_arbiter: RTL and testbench

Round-robin AHB bus arbiter that shares the single AHB slave port of the AHB-to-APB bridge among up to `NUM_MASTERS` AHB masters. It owns the grant state machine and the address/data-phase multiplexers. It issues one-hot grants, tracks address-phase and data-phase ownership separately, and enforces a maximum tenure so that no requester can starve the others. It sits between the master instances and the bridge's `hwrite/hreadyin/htrans/hwdata/haddr` inputs.

---
 rtl/ahb_arbiter_if.sv | 34 +++
 rtl/ahb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// Bus bundle between the AHB masters and the arbiter in front of the AHB-to-APB bridge.
// The slave modport is the arbiter side; the master modport is the requester/bridge side.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]    hbusreq;
    logic [2*NUM_MASTERS-1:0]  m_htrans;
    logic [32*NUM_MASTERS-1:0] m_haddr;
    logic [NUM_MASTERS-1:0]    m_hwrite;
    logic [32*NUM_MASTERS-1:0] m_hwdata;
    logic                      hreadyout;
    logic [1:0]                hresp;

    logic [NUM_MASTERS-1:0]    hgrant;
    logic [MW-1:0]             hmaster;
    logic [1:0]                htrans;
    logic [31:0]               haddr;
    logic                      hwrite;
    logic [31:0]               hwdata;
    logic                      hreadyin;
    logic                      hready_m;
    logic [1:0]                hresp_m;

    modport slave (
        input  hbusreq, m_htrans, m_haddr, m_hwrite, m_hwdata, hreadyout, hresp,
        output hgrant, hmaster, htrans, haddr, hwrite, hwdata, hreadyin, hready_m, hresp_m
    );

    modport master (
        output hbusreq, m_htrans, m_haddr, m_hwrite, m_hwdata, hreadyout, hresp,
        input  hgrant, hmaster, htrans, haddr, hwrite, hwdata, hreadyin, hready_m, hresp_m
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with bounded tenure; muxes the owner's address phase and the
// data-phase owner's write data onto the single bridge slave port.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic         hclk,
    input  logic         hresetn,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        PARK     = 2'd0,
        OWN      = 2'd1,
        HANDOVER = 2'd2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [7:0] TENURE_MAX  = 8'(MAX_TENURE);

    state_e          state_q, state_d;
    logic [MW-1:0]   owner_q, owner_d;
    logic [MW-1:0]   last_q, last_d;
    logic [7:0]      tenure_q, tenure_d;
    logic            data_valid_q, data_valid_d;
    logic [MW-1:0]   data_owner_q, data_owner_d;
    logic [31:0]     haddr_q, haddr_d;
    logic            hwrite_q, hwrite_d;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic [1:0]             own_htrans;
    logic [31:0]            own_haddr;
    logic                   own_hwrite;
    logic                   own_active;
    logic                   any_req;
    logic                   other_req;
    logic                   found;
    logic [MW-1:0]          winner;

    assign owner_oh   = NUM_MASTERS'(1) << owner_q;
    assign own_htrans = bus.m_htrans[{owner_q, 1'b0} +: 2];
    assign own_haddr  = bus.m_haddr[{owner_q, 5'd0} +: 32];
    assign own_hwrite = bus.m_hwrite[owner_q];
    assign own_active = own_htrans[1];
    assign any_req    = |bus.hbusreq;
    assign other_req  = |(bus.hbusreq & ~owner_oh);

    // First requester at or after last_owner+1, wrapping; the last owner is checked last.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!found && bus.hbusreq[(int'(last_q) + i) % NUM_MASTERS]) begin
                winner = MW'((int'(last_q) + i) % NUM_MASTERS);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        tenure_d     = tenure_q;
        data_valid_d = data_valid_q;
        data_owner_d = data_owner_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;

        unique case (state_q)
            PARK: begin
                if (any_req) begin
                    state_d  = OWN;
                    owner_d  = winner;
                    last_d   = winner;
                    tenure_d = '0;
                end
            end
            OWN: begin
                haddr_d  = own_haddr;
                hwrite_d = own_hwrite;
                if (bus.hreadyout) begin
                    if (own_active && tenure_q < TENURE_MAX) tenure_d = tenure_q + 8'd1;
                    // tenure_d includes this cycle's phase, so the limit lands on the last accepted one.
                    if ((own_htrans == HTRANS_IDLE && !bus.hbusreq[owner_q]) ||
                        (tenure_d >= TENURE_MAX && other_req)) begin
                        state_d = HANDOVER;
                    end
                end
            end
            HANDOVER: begin
                if (bus.hreadyout) begin
                    if (any_req) begin
                        state_d  = OWN;
                        owner_d  = winner;
                        last_d   = winner;
                        tenure_d = '0;
                    end else begin
                        state_d = PARK;
                    end
                end
            end
            default: state_d = PARK;
        endcase

        if (bus.hreadyout) begin
            data_valid_d = (state_q == OWN) && own_active;
            data_owner_d = owner_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q      <= PARK;
            owner_q      <= '0;
            last_q       <= MW'(NUM_MASTERS - 1);
            tenure_q     <= '0;
            data_valid_q <= 1'b0;
            data_owner_q <= '0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            tenure_q     <= tenure_d;
            data_valid_q <= data_valid_d;
            data_owner_q <= data_owner_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
        end
    end

    always_comb begin
        bus.hgrant = '0;
        bus.htrans = HTRANS_IDLE;
        bus.haddr  = '0;
        bus.hwrite = 1'b0;
        case (state_q)
            OWN: begin
                bus.hgrant = owner_oh;
                bus.htrans = own_htrans;
                bus.haddr  = own_haddr;
                bus.hwrite = own_hwrite;
            end
            HANDOVER: begin
                bus.haddr  = haddr_q;
                bus.hwrite = hwrite_q;
            end
            default: ;
        endcase
    end

    assign bus.hmaster  = owner_q;
    assign bus.hwdata   = data_valid_q ? bus.m_hwdata[{data_owner_q, 5'd0} +: 32] : '0;
    assign bus.hreadyin = bus.hreadyout;
    assign bus.hready_m = bus.hreadyout;
    assign bus.hresp_m  = bus.hresp;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: per-cycle stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares them against the bridge- and master-side outputs.
module tb_ahb_arbiter;
    localparam int N  = 4;
    localparam int MW = 2;
    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, ERR = 2'b01;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    ahb_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

    ahb_arbiter #(.NUM_MASTERS(N), .MAX_TENURE(4), .MW(MW)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    logic [31:0]  a_m [N];
    logic [31:0]  d_m [N];
    logic [N-1:0] w_m = 4'b0110;

    typedef struct {
        logic [N-1:0] grant;
        int           mst;
        logic [1:0]   trans;
        logic [31:0]  addr;
        logic         hwrite;
        logic [31:0]  wdata;
        logic         rdy;
        logic [1:0]   resp;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
        end
    endtask

    function automatic logic [7:0] tr_of(input int m, input logic [1:0] t);
        tr_of = 8'(t) << (2 * m);
    endfunction

    // ea/ed: master index whose address/data is expected, -1 for zero; em: -1 skips hmaster.
    task automatic step(input logic rst, input logic [3:0] req, input logic [7:0] tr,
                        input logic rdy, input logic [1:0] rsp,
                        input logic [3:0] eg, input int em, input logic [1:0] et,
                        input int ea, input int ed);
        exp_t e;
        @(posedge hclk);
        #2;
        cyc++;
        hresetn       = rst;
        bus.hbusreq   = req;
        bus.m_htrans  = tr;
        bus.hreadyout = rdy;
        bus.hresp     = rsp;
        bus.m_hwrite  = w_m;
        for (int i = 0; i < N; i++) begin
            bus.m_haddr[32*i +: 32]  = a_m[i];
            bus.m_hwdata[32*i +: 32] = d_m[i];
        end
        e.grant  = eg;
        e.mst    = em;
        e.trans  = et;
        e.addr   = (ea < 0) ? 32'h0 : a_m[ea];
        e.hwrite = (ea < 0) ? 1'b0 : w_m[ea];
        e.wdata  = (ed < 0) ? 32'h0 : d_m[ed];
        e.rdy    = rdy;
        e.resp   = rsp;
        e.cyc    = cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hgrant", e.cyc, 32'(bus.hgrant), 32'(e.grant));
                if (e.mst >= 0) check("hmaster", e.cyc, 32'(bus.hmaster), e.mst);
                check("htrans",   e.cyc, 32'(bus.htrans),   32'(e.trans));
                check("haddr",    e.cyc, bus.haddr,         e.addr);
                check("hwrite",   e.cyc, 32'(bus.hwrite),   32'(e.hwrite));
                check("hwdata",   e.cyc, bus.hwdata,        e.wdata);
                check("hreadyin", e.cyc, 32'(bus.hreadyin), 32'(e.rdy));
                check("hready_m", e.cyc, 32'(bus.hready_m), 32'(e.rdy));
                check("hresp_m",  e.cyc, 32'(bus.hresp_m),  32'(e.resp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        a_m = '{32'h8000_FFFF, 32'h8000_1111, 32'h8000_0011, 32'h8000_3333};
        d_m = '{32'h0000_0000, 32'h8000_0BBB, 32'h8000_0CCC, 32'h8000_0DDD};
        hresetn       = 1'b0;
        bus.hbusreq   = '0;
        bus.m_htrans  = '0;
        bus.m_haddr   = '0;
        bus.m_hwrite  = '0;
        bus.m_hwdata  = '0;
        bus.hreadyout = 1'b1;
        bus.hresp     = OKAY;

        // Reset values, then a single read by master 0.
        step(0, 4'h0, 8'h00,            1, OKAY, 4'h0, 0,  IDLE, -1, -1);
        step(1, 4'h1, tr_of(0, NSEQ),   1, OKAY, 4'h0, 0,  IDLE, -1, -1);
        step(1, 4'h1, tr_of(0, NSEQ),   1, OKAY, 4'h1, 0,  NSEQ,  0, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h1, 0,  IDLE,  0,  0);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE,  0, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE, -1, -1);
        d_m[0] = 32'h8000_0AAA;

        // Single write by master 2 with a two-cycle data-phase stall.
        step(1, 4'h4, tr_of(2, NSEQ),   1, OKAY, 4'h0, -1, IDLE, -1, -1);
        step(1, 4'h4, tr_of(2, NSEQ),   1, OKAY, 4'h4, 2,  NSEQ,  2, -1);
        step(1, 4'h0, 8'h00,            0, OKAY, 4'h4, 2,  IDLE,  2,  2);
        step(1, 4'h0, 8'h00,            0, OKAY, 4'h4, 2,  IDLE,  2,  2);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h4, 2,  IDLE,  2,  2);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE,  2, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE, -1, -1);

        // Master 1 alone for 10 transfers; ERROR responses only pass through.
        step(1, 4'h2, tr_of(1, NSEQ),   1, OKAY, 4'h0, -1, IDLE, -1, -1);
        step(1, 4'h2, tr_of(1, NSEQ),   1, OKAY, 4'h2, 1,  NSEQ,  1, -1);
        for (int i = 0; i < 9; i++)
            step(1, 4'h2, tr_of(1, SEQ), 1, (i == 2 || i == 3) ? ERR : OKAY, 4'h2, 1, SEQ, 1, 1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h2, 1,  IDLE,  1,  1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE,  1, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE, -1, -1);

        // Reset while master 3 has a data phase outstanding.
        step(1, 4'h8, tr_of(3, NSEQ),   1, OKAY, 4'h0, -1, IDLE, -1, -1);
        step(1, 4'h8, tr_of(3, NSEQ),   1, OKAY, 4'h8, 3,  NSEQ,  3, -1);
        step(0, 4'h8, tr_of(3, SEQ),    1, OKAY, 4'h8, 3,  SEQ,   3,  3);
        step(1, 4'hF, 8'hAA,            1, OKAY, 4'h0, 0,  IDLE, -1, -1);

        // All four request: 4 phases then one handover each; master 1's handover stalls 3 cycles.
        for (int m = 0; m < N; m++) begin
            step(1, 4'hF, 8'hAA, 1, OKAY, 4'(1 << m), m, NSEQ, m, -1);
            for (int j = 0; j < 3; j++)
                step(1, 4'hF, 8'hAA, 1, OKAY, 4'(1 << m), m, NSEQ, m, m);
            if (m == 1)
                for (int j = 0; j < 3; j++)
                    step(1, 4'hF, 8'hAA, 0, OKAY, 4'h0, -1, IDLE, m, m);
            step(1, 4'hF, 8'hAA, 1, OKAY, 4'h0, -1, IDLE, m, m);
        end
        step(1, 4'hF, 8'hAA,            1, OKAY, 4'h1, 0,  NSEQ,  0, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h1, 0,  IDLE,  0,  0);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE,  0, -1);
        step(1, 4'h0, 8'h00,            1, OKAY, 4'h0, -1, IDLE, -1, -1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge hclk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
